mult_arbiter: RTL
=================

# mult_arbiter

Round-robin arbiter and sequencer that shares one combinational `multiplier` datapath instance among `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester, registers its operands and registers the product. It then returns the result on a per-requester response handshake. It sits between client blocks and the single shared multiplier, so no client ever drives the datapath directly.

## Interface
- `BIT_WIDTH`, 8: operand and result width; passed through to the `multiplier` instance.
- `NUM_REQ`, 4: number of requesters, 2..8.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `req_valid`  in  NUM_REQ: requester i has an operand pair pending.
- `req_ready`  out  NUM_REQ: one-hot grant; the request is accepted when `req_valid[i] && req_ready[i]`.
- `req_a`  in  NUM_REQ*BIT_WIDTH: packed operand A; slice i belongs to requester i.
- `req_b`  in  NUM_REQ*BIT_WIDTH: packed operand B.
- `rsp_valid`  out  NUM_REQ: one-hot; result ready for requester i.
- `rsp_ready`  in  NUM_REQ: requester i consumes its result.
- `rsp_result`  out  BIT_WIDTH: product for the requester flagged in `rsp_valid`.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- FSM states are IDLE, BUSY and DONE.
- **IDLE**
  - If any `req_valid` is set, pick the first set bit at or after `rr_ptr`, searching cyclically. Assert `req_ready` for that index only; this is combinational from `req_valid`.
  - On that edge, register the A/B slices into `op_a`/`op_b`, register the index into `gnt_id`, and go to BUSY.
  - If no `req_valid` bit is set, stay in IDLE with `req_ready` = 0.
- **BUSY**
  - The `multiplier` is fed from `op_a`/`op_b`.
  - On the edge, register its output into `res_q` and go to DONE.
  - `req_ready` = 0.
- **DONE**
  - Drive `rsp_valid[gnt_id]` = 1 and `rsp_result` = `res_q`.
  - On `rsp_ready[gnt_id]`: go to IDLE and set `rr_ptr` = (`gnt_id` + 1) mod `NUM_REQ`.
  - `rsp_ready` bits of other requesters are ignored.
- **Arithmetic**
  - `rsp_result` = (A × B) mod 2^BIT_WIDTH, i.e. the low BIT_WIDTH bits; the high product bits are discarded.
  - Operands are unsigned.
- **Protocol rules**
  - A requester holds `req_valid` and its operands stable until accepted.
  - Deasserting `req_valid` before the grant edge simply withdraws the request.
  - `rsp_valid` and `rsp_result` stay stable until consumed.
- `rr_ptr` changes only on response completion, never on accept.

## Timing
- **Reset values:** `req_ready` = 0, `rsp_valid` = 0, `rsp_result` = 0, `busy` = 0, state IDLE, `rr_ptr` = 0, `gnt_id` = 0.
- **Latency:**
  - Accept edge at cycle 0.
  - `rsp_valid` asserted from cycle 2, i.e. after two edges.
  - Minimum 3 cycles per transaction with `rsp_ready` tied high.
- **Throughput:**
  - At most one transaction in flight.
  - No new `req_ready` is asserted in the DONE→IDLE transition cycle. The next grant is possible in the first IDLE cycle.
- **Simultaneous requests:** exactly one grant per IDLE cycle; the others wait with `req_ready` = 0.
- **Wrap-around:** the search from `rr_ptr` = NUM_REQ−1 continues at index 0.
- **Reset mid-operation:** the transaction is dropped and no response is ever issued. All outputs go to reset values asynchronously when `rst_n` falls.
- **Backpressure:** DONE may last any number of cycles. `busy` stays 1 throughout.

## Structure
- Package `mult_arb_pkg` holds:
  - the state enum (IDLE/BUSY/DONE, 2 bits);
  - default localparams for `BIT_WIDTH` and `NUM_REQ`;
  - a round-robin pick function (request vector, pointer → index).
- One sub-module: the existing `multiplier`, instantiated once with `bit_width` = `BIT_WIDTH`.
- `mult_arbiter` does not re-implement any arithmetic.
- The arbitration logic stays inline; it is small enough that no separate module is warranted.

## Test plan
- **Single requester:**
  - Stimulus: requester 2, A=5, B=7, `rsp_ready` high.
  - Response: `req_ready` = 0b0100 at cycle 0; `rsp_valid` = 0b0100 and `rsp_result` = 35 at cycle 2; back to IDLE at cycle 3.
- **Truncation:**
  - 20×13 → `rsp_result` = 4 (260 mod 256).
  - 255×255 → 1.
- **Fairness:**
  - Stimulus: all four `req_valid` held high from reset.
  - Response: grants occur in order 0,1,2,3,0. `rr_ptr` = 1 after the first response completes.
- **Backpressure:**
  - Stimulus: hold `rsp_ready[1]` low for 5 cycles in DONE; pulse `rsp_ready[0]` meanwhile.
  - Response: `rsp_valid[1]` and `rsp_result` remain stable, `busy` = 1, and no new grant is issued. Completion occurs only on `rsp_ready[1]`.
- **Reset mid-operation:**
  - Stimulus: drop `rst_n` in BUSY.
  - Response: all outputs 0 immediately. After release, with no `req_valid`, no `rsp_valid` ever appears. A fresh request from index 3 is granted as the first grant, with `rr_ptr` = 0 search order.
- **Withdrawal:**
  - Stimulus: `req_valid[1]` pulsed for one cycle while DONE for requester 0.
  - Response: no grant to requester 1; the block returns to IDLE with `req_ready` = 0.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared types, defaults and the round-robin pick helper for mult_arbiter.
package mult_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int DEF_BIT_WIDTH = 8;
    localparam int DEF_NUM_REQ   = 4;

    // First set bit of req at or after ptr, wrapping at n; returns ptr when nothing is set.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
        int j;
        logic hit;
        rr_pick = ptr;
        hit     = 1'b0;
        for (int k = 0; k < 8; k++) begin
            j = (int'(ptr) + k) % n;
            if (!hit && k < n && req[j[2:0]]) begin
                rr_pick = j[2:0];
                hit     = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/multiplier.sv
// multiplier: unsigned combinational multiply, low bit_width bits of the product.
module multiplier #(
    parameter int bit_width = 8
) (
    input  logic [bit_width-1:0] a_i,
    input  logic [bit_width-1:0] b_i,
    output logic [bit_width-1:0] p_o
);

    assign p_o = a_i * b_i;

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one multiplier among NUM_REQ requesters,
// one transaction in flight, result returned on a per-requester response handshake.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int NUM_REQ   = DEF_NUM_REQ
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [BIT_WIDTH-1:0]         rsp_result,
    output logic                         busy
);

    localparam int IW = $clog2(NUM_REQ);

    state_t               state_q, state_d;
    logic [BIT_WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d, prod;
    logic [IW-1:0]        gnt_q, gnt_d, ptr_q, ptr_d, pick;

    assign pick = IW'(rr_pick(8'(req_valid), 3'(ptr_q), NUM_REQ));

    multiplier #(.bit_width(BIT_WIDTH)) u_mul (
        .a_i(op_a_q),
        .b_i(op_b_q),
        .p_o(prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // The grant is gated by rst_n so req_ready reads 0 while reset is held.
    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        res_d     = res_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        req_ready = '0;
        rsp_valid = '0;
        case (state_q)
            IDLE: if (rst_n && |req_valid) begin
                req_ready[pick] = 1'b1;
                op_a_d          = req_a[pick*BIT_WIDTH +: BIT_WIDTH];
                op_b_d          = req_b[pick*BIT_WIDTH +: BIT_WIDTH];
                gnt_d           = pick;
                state_d         = BUSY;
            end
            BUSY: begin
                res_d   = prod;
                state_d = DONE;
            end
            DONE: begin
                rsp_valid[gnt_q] = 1'b1;
                if (rsp_ready[gnt_q]) begin
                    ptr_d   = (32'(gnt_q) == NUM_REQ - 1) ? '0 : gnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_result = (state_q == DONE) ? res_q : '0;
    assign busy       = state_q != IDLE;

endmodule
